// File: rtl/mem_rw_bank_arbiter.sv
// Banked read/write arbiter: one lane per memory bank. Each lane picks
// between a read-side and a write-side requester, forwards the winner to a
// single-ported bank, and routes bank responses back to the side that issued
// the matching request using a small in-order tag FIFO.

package axi_pkg;
    // Atomic-operation encoding carried alongside each bank request.
    typedef logic [5:0] atop_t;
endpackage

module mem_rw_bank_arbiter #(
    parameter int unsigned NumBanks       = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   busy_o,

    // Read-side requester
    input  logic [NumBanks-1:0]    rd_req_i,
    output logic [NumBanks-1:0]    rd_gnt_o,
    input  logic [AddrWidth-1:0]   rd_addr_i  [NumBanks],
    input  logic [DataWidth-1:0]   rd_wdata_i [NumBanks],
    input  logic [DataWidth/8-1:0] rd_strb_i  [NumBanks],
    input  axi_pkg::atop_t         rd_atop_i  [NumBanks],
    input  logic [NumBanks-1:0]    rd_we_i,
    output logic [NumBanks-1:0]    rd_rvalid_o,
    output logic [DataWidth-1:0]   rd_rdata_o [NumBanks],

    // Write-side requester
    input  logic [NumBanks-1:0]    wr_req_i,
    output logic [NumBanks-1:0]    wr_gnt_o,
    input  logic [AddrWidth-1:0]   wr_addr_i  [NumBanks],
    input  logic [DataWidth-1:0]   wr_wdata_i [NumBanks],
    input  logic [DataWidth/8-1:0] wr_strb_i  [NumBanks],
    input  axi_pkg::atop_t         wr_atop_i  [NumBanks],
    input  logic [NumBanks-1:0]    wr_we_i,
    output logic [NumBanks-1:0]    wr_rvalid_o,
    output logic [DataWidth-1:0]   wr_rdata_o [NumBanks],

    // Single-ported bank side
    output logic [NumBanks-1:0]    mem_req_o,
    input  logic [NumBanks-1:0]    mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o  [NumBanks],
    output logic [DataWidth-1:0]   mem_wdata_o [NumBanks],
    output logic [DataWidth/8-1:0] mem_strb_o  [NumBanks],
    output axi_pkg::atop_t         mem_atop_o  [NumBanks],
    output logic [NumBanks-1:0]    mem_we_o,
    input  logic [NumBanks-1:0]    mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i [NumBanks]
);

    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        SideRd = 1'b0,
        SideWr = 1'b1
    } side_e;

    typedef enum logic {
        LockFree = 1'b0,
        LockHeld = 1'b1
    } lock_e;

    logic [NumBanks-1:0] lane_busy;

    assign busy_o = |lane_busy;

    for (genvar b = 0; b < NumBanks; b++) begin : g_lane
        side_e                prio_q;
        side_e                sel_q;
        side_e                sel;
        lock_e                lock_q;
        lock_e                lock_d;
        logic                 sel_req;
        logic                 mem_req;
        logic                 handshake;
        logic                 full;
        logic                 empty;
        logic                 push;
        logic                 pop;
        side_e                head;
        logic [CntWidth-1:0]  cnt_q;
        logic [CntWidth-1:0]  cnt_d;
        logic [PtrWidth-1:0]  wptr_q;
        logic [PtrWidth-1:0]  rptr_q;
        side_e                tags_q [MaxOutstanding];

        assign full  = (cnt_q == CntWidth'(MaxOutstanding));
        assign empty = (cnt_q == '0);

        // Side selection, bank request gating and lock next-state.
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        always_comb begin
            sel     = SideRd;
            lock_d  = lock_q;
            if (lock_q == LockHeld) begin
                sel = sel_q;
            end else if (rd_req_i[b] && wr_req_i[b]) begin
                sel = prio_q;
            end else if (wr_req_i[b]) begin
                sel = SideWr;
            end
            sel_req   = (sel == SideWr) ? wr_req_i[b] : rd_req_i[b];
            // Gated by the registered count only, so a same-cycle response
            // never opens a combinational rvalid-to-req path.
            mem_req   = sel_req && !full;
            handshake = mem_req && mem_gnt_i[b];
            case (lock_q)
                LockFree: if (mem_req && !mem_gnt_i[b]) lock_d = LockHeld;
                LockHeld: if (handshake || !sel_req)    lock_d = LockFree;
                default:  lock_d = LockFree;
            endcase
        end

        // Arbitration state: round-robin priority, lock and held side.
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                prio_q <= SideRd;
                sel_q  <= SideRd;
                lock_q <= LockFree;
            end else begin
                lock_q <= lock_d;
                sel_q  <= sel;
                if (handshake) begin
                    prio_q <= (sel == SideRd) ? SideWr : SideRd;
                end
            end
        end

        assign push = handshake;
        assign pop  = mem_rvalid_i[b] && !empty;
        assign head = tags_q[rptr_q];

        // Tag FIFO occupancy; simultaneous push and pop leaves it unchanged.
        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop) begin
                cnt_d = cnt_q + CntWidth'(1);
            end else if (!push && pop) begin
                cnt_d = cnt_q - CntWidth'(1);
            end
        end

        // Tag FIFO pointers and count; reset discards all outstanding tags.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push) begin
                    wptr_q <= (wptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrWidth'(1);
                end
                if (pop) begin
                    rptr_q <= (rptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrWidth'(1);
                end
            end
        end

        // Tag storage write port.
        // NOTE: storage is not reset; an entry is only read after it has
        // been written, and the pointers/count carry all validity.
        always_ff @(posedge clk_i) begin
            if (push) begin
                tags_q[wptr_q] <= sel;
            end
        end

        // Bank-side request and payload from the selected side.
        assign mem_req_o[b]   = mem_req;
        assign mem_addr_o[b]  = (sel == SideWr) ? wr_addr_i[b]  : rd_addr_i[b];
        assign mem_wdata_o[b] = (sel == SideWr) ? wr_wdata_i[b] : rd_wdata_i[b];
        assign mem_strb_o[b]  = (sel == SideWr) ? wr_strb_i[b]  : rd_strb_i[b];
        assign mem_atop_o[b]  = (sel == SideWr) ? wr_atop_i[b]  : rd_atop_i[b];
        assign mem_we_o[b]    = (sel == SideWr) ? wr_we_i[b]    : rd_we_i[b];

        // Grant goes only to the selected side.
        assign rd_gnt_o[b] = handshake && (sel == SideRd);
        assign wr_gnt_o[b] = handshake && (sel == SideWr);

        // Responses follow the head tag; a response with no tag is dropped.
        assign rd_rvalid_o[b] = pop && (head == SideRd);
        assign wr_rvalid_o[b] = pop && (head == SideWr);
        assign rd_rdata_o[b]  = rd_rvalid_o[b] ? mem_rdata_i[b] : '0;
        assign wr_rdata_o[b]  = wr_rvalid_o[b] ? mem_rdata_i[b] : '0;

        assign lane_busy[b] = rd_req_i[b] || wr_req_i[b] || !empty;

        // A response must never arrive with nothing outstanding.
        a_no_orphan_rvalid: assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            mem_rvalid_i[b] |-> !empty
        );

        // A pending read request must be held stable until granted.
        a_rd_hold: assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            (rd_req_i[b] && !rd_gnt_o[b]) |=>
                (rd_req_i[b] && $stable(rd_addr_i[b]) && $stable(rd_wdata_i[b]) &&
                 $stable(rd_strb_i[b]) && $stable(rd_atop_i[b]) && $stable(rd_we_i[b]))
        );

        // A pending write request must be held stable until granted.
        a_wr_hold: assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            (wr_req_i[b] && !wr_gnt_o[b]) |=>
                (wr_req_i[b] && $stable(wr_addr_i[b]) && $stable(wr_wdata_i[b]) &&
                 $stable(wr_strb_i[b]) && $stable(wr_atop_i[b]) && $stable(wr_we_i[b]))
        );
    end

endmodule

// File: tb/tb_mem_rw_bank_arbiter.sv
// Directed self-checking bench for mem_rw_bank_arbiter (default parameters).

module tb_mem_rw_bank_arbiter;

    localparam int unsigned NumBanks  = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   busy_o;

    logic [NumBanks-1:0]    rd_req_i, rd_gnt_o, rd_we_i, rd_rvalid_o;
    logic [AddrWidth-1:0]   rd_addr_i  [NumBanks];
    logic [DataWidth-1:0]   rd_wdata_i [NumBanks];
    logic [DataWidth/8-1:0] rd_strb_i  [NumBanks];
    axi_pkg::atop_t         rd_atop_i  [NumBanks];
    logic [DataWidth-1:0]   rd_rdata_o [NumBanks];

    logic [NumBanks-1:0]    wr_req_i, wr_gnt_o, wr_we_i, wr_rvalid_o;
    logic [AddrWidth-1:0]   wr_addr_i  [NumBanks];
    logic [DataWidth-1:0]   wr_wdata_i [NumBanks];
    logic [DataWidth/8-1:0] wr_strb_i  [NumBanks];
    axi_pkg::atop_t         wr_atop_i  [NumBanks];
    logic [DataWidth-1:0]   wr_rdata_o [NumBanks];

    logic [NumBanks-1:0]    mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [AddrWidth-1:0]   mem_addr_o  [NumBanks];
    logic [DataWidth-1:0]   mem_wdata_o [NumBanks];
    logic [DataWidth/8-1:0] mem_strb_o  [NumBanks];
    axi_pkg::atop_t         mem_atop_o  [NumBanks];
    logic [DataWidth-1:0]   mem_rdata_i [NumBanks];

    int vectors     = 0;
    int miscompares = 0;

    // Expected winning side per cycle on lane 0 (1 = write), first cycle at bit 0.
    logic [3:0] l0_wr = 4'b1010;

    always #5 clk_i = ~clk_i;

    mem_rw_bank_arbiter #(
        .NumBanks       (NumBanks),
        .AddrWidth      (AddrWidth),
        .DataWidth      (DataWidth),
        .MaxOutstanding (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .busy_o       (busy_o),
        .rd_req_i     (rd_req_i),
        .rd_gnt_o     (rd_gnt_o),
        .rd_addr_i    (rd_addr_i),
        .rd_wdata_i   (rd_wdata_i),
        .rd_strb_i    (rd_strb_i),
        .rd_atop_i    (rd_atop_i),
        .rd_we_i      (rd_we_i),
        .rd_rvalid_o  (rd_rvalid_o),
        .rd_rdata_o   (rd_rdata_o),
        .wr_req_i     (wr_req_i),
        .wr_gnt_o     (wr_gnt_o),
        .wr_addr_i    (wr_addr_i),
        .wr_wdata_i   (wr_wdata_i),
        .wr_strb_i    (wr_strb_i),
        .wr_atop_i    (wr_atop_i),
        .wr_we_i      (wr_we_i),
        .wr_rvalid_o  (wr_rvalid_o),
        .wr_rdata_o   (wr_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_strb_o   (mem_strb_o),
        .mem_atop_o   (mem_atop_o),
        .mem_we_o     (mem_we_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        rd_req_i     = '0;
        wr_req_i     = '0;
        rd_we_i      = '0;
        wr_we_i      = '0;
        mem_gnt_i    = '0;
        mem_rvalid_i = '0;
        for (int i = 0; i < NumBanks; i++) begin
            rd_addr_i[i]   = '0;
            rd_wdata_i[i]  = '0;
            rd_strb_i[i]   = '0;
            rd_atop_i[i]   = '0;
            wr_addr_i[i]   = '0;
            wr_wdata_i[i]  = '0;
            wr_strb_i[i]   = '0;
            wr_atop_i[i]   = '0;
            mem_rdata_i[i] = '0;
        end
    endtask

    // Advance one cycle and land just after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        #12;
        check("rst_mem_req",   mem_req_o,   4'h0);
        check("rst_rd_gnt",    rd_gnt_o,    4'h0);
        check("rst_wr_gnt",    wr_gnt_o,    4'h0);
        check("rst_rd_rvalid", rd_rvalid_o, 4'h0);
        check("rst_wr_rvalid", wr_rvalid_o, 4'h0);
        check("rst_busy",      busy_o,      1'b0);
        tick();
        rst_ni = 1'b1;

        // Lane 0: both sides requesting, bank always ready -> rd,wr,rd,wr.
        rd_req_i[0]  = 1'b1;
        rd_addr_i[0] = 32'h0000_0100;
        wr_req_i[0]  = 1'b1;
        wr_addr_i[0] = 32'h0000_0200;
        wr_we_i[0]   = 1'b1;
        mem_gnt_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) rd_req_i[0] = 1'b0;
            #1;
            check("l0_rd_gnt", rd_gnt_o[0], !l0_wr[k]);
            check("l0_wr_gnt", wr_gnt_o[0], l0_wr[k]);
            check("l0_addr",   mem_addr_o[0], l0_wr[k] ? 32'h200 : 32'h100);
            tick();
        end
        wr_req_i[0]  = 1'b0;
        wr_we_i[0]   = 1'b0;
        mem_gnt_i[0] = 1'b0;
        #1;
        check("l0_busy_tags", busy_o, 1'b1);
        // Responses come back tagged 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i[0] = 1'b1;
            mem_rdata_i[0]  = 32'hA0 + k;
            #1;
            check("l0_rd_rvalid", rd_rvalid_o[0], !l0_wr[k]);
            check("l0_wr_rvalid", wr_rvalid_o[0], l0_wr[k]);
            check("l0_rd_rdata",  rd_rdata_o[0], l0_wr[k] ? 32'h0 : 32'hA0 + k);
            check("l0_wr_rdata",  wr_rdata_o[0], l0_wr[k] ? 32'hA0 + k : 32'h0);
            tick();
        end
        mem_rvalid_i[0] = 1'b0;
        mem_rdata_i[0]  = '0;
        #1;
        check("l0_busy_drained", busy_o, 1'b0);

        // Lane 2: write-only request, payload passes through in the same cycle.
        wr_req_i[2]   = 1'b1;
        wr_addr_i[2]  = 32'h0000_0040;
        wr_wdata_i[2] = 32'hDEAD_BEEF;
        wr_strb_i[2]  = 4'hF;
        wr_atop_i[2]  = 6'h21;
        wr_we_i[2]    = 1'b1;
        mem_gnt_i[2]  = 1'b1;
        #1;
        check("l2_mem_req",   mem_req_o,      4'b0100);
        check("l2_addr",      mem_addr_o[2],  32'h40);
        check("l2_wdata",     mem_wdata_o[2], 32'hDEAD_BEEF);
        check("l2_strb",      mem_strb_o[2],  4'hF);
        check("l2_atop",      mem_atop_o[2],  6'h21);
        check("l2_we",        mem_we_o[2],    1'b1);
        check("l2_wr_gnt",    wr_gnt_o[2],    1'b1);
        check("l2_rd_gnt",    rd_gnt_o[2],    1'b0);
        tick();
        wr_req_i[2]  = 1'b0;
        wr_we_i[2]   = 1'b0;
        mem_gnt_i[2] = 1'b0;
        tick();
        mem_rvalid_i[2] = 1'b1;
        mem_rdata_i[2]  = 32'h1234_5678;
        #1;
        check("l2_wr_rvalid", wr_rvalid_o[2], 1'b1);
        check("l2_rd_rvalid", rd_rvalid_o[2], 1'b0);
        check("l2_wr_rdata",  wr_rdata_o[2],  32'h1234_5678);
        check("l2_rd_rdata",  rd_rdata_o[2],  32'h0);
        tick();
        mem_rvalid_i[2] = 1'b0;

        // Lane 1: a read handshake first so priority points at the write side.
        rd_req_i[1]  = 1'b1;
        rd_addr_i[1] = 32'h0000_0010;
        mem_gnt_i[1] = 1'b1;
        #1;
        check("l1_prep_gnt", rd_gnt_o[1], 1'b1);
        tick();
        rd_req_i[1]     = 1'b0;
        mem_gnt_i[1]    = 1'b0;
        mem_rvalid_i[1] = 1'b1;
        mem_rdata_i[1]  = 32'h55;
        #1;
        check("l1_prep_rvalid", rd_rvalid_o[1], 1'b1);
        tick();
        mem_rvalid_i[1] = 1'b0;
        // Read stalls for three cycles; write joins in the second.
        rd_req_i[1]  = 1'b1;
        rd_addr_i[1] = 32'h0000_0014;
        #1;
        check("l1_stall_req",  mem_req_o[1],  1'b1);
        check("l1_stall_addr", mem_addr_o[1], 32'h14);
        check("l1_stall_gnt",  rd_gnt_o[1],   1'b0);
        tick();
        wr_req_i[1]  = 1'b1;
        wr_addr_i[1] = 32'h0000_0024;
        wr_we_i[1]   = 1'b1;
        #1;
        check("l1_lock_addr",   mem_addr_o[1], 32'h14);
        check("l1_lock_we",     mem_we_o[1],   1'b0);
        check("l1_lock_wr_gnt", wr_gnt_o[1],   1'b0);
        tick();
        #1;
        check("l1_lock2_addr",  mem_addr_o[1], 32'h14);
        check("l1_lock2_wrgnt", wr_gnt_o[1],   1'b0);
        tick();
        mem_gnt_i[1] = 1'b1;
        #1;
        check("l1_rel_rd_gnt", rd_gnt_o[1], 1'b1);
        check("l1_rel_wr_gnt", wr_gnt_o[1], 1'b0);
        tick();
        rd_req_i[1] = 1'b0;
        #1;
        check("l1_next_wr_gnt", wr_gnt_o[1],   1'b1);
        check("l1_next_addr",   mem_addr_o[1], 32'h24);
        tick();
        wr_req_i[1]     = 1'b0;
        wr_we_i[1]      = 1'b0;
        mem_gnt_i[1]    = 1'b0;
        mem_rvalid_i[1] = 1'b1;
        #1;
        check("l1_resp0_rd", rd_rvalid_o[1], 1'b1);
        check("l1_resp0_wr", wr_rvalid_o[1], 1'b0);
        tick();
        #1;
        check("l1_resp1_rd", rd_rvalid_o[1], 1'b0);
        check("l1_resp1_wr", wr_rvalid_o[1], 1'b1);
        tick();
        mem_rvalid_i[1] = 1'b0;

        // Lane 3: fill the tag FIFO, then show the full-gating rules.
        rd_req_i[3]  = 1'b1;
        rd_addr_i[3] = 32'h0000_0300;
        mem_gnt_i[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("l3_fill_gnt", rd_gnt_o[3], 1'b1);
            tick();
        end
        #1;
        check("l3_full_req",  mem_req_o[3], 1'b0);
        check("l3_full_gnt",  rd_gnt_o[3],  1'b0);
        check("l3_full_busy", busy_o,       1'b1);
        tick();
        mem_rvalid_i[3] = 1'b1;
        mem_rdata_i[3]  = 32'h77;
        #1;
        check("l3_pop_full_req", mem_req_o[3],   1'b0);
        check("l3_pop_rvalid",   rd_rvalid_o[3], 1'b1);
        tick();
        #1;
        check("l3_pushpop_req",    mem_req_o[3],   1'b1);
        check("l3_pushpop_gnt",    rd_gnt_o[3],    1'b1);
        check("l3_pushpop_rvalid", rd_rvalid_o[3], 1'b1);
        tick();
        mem_rvalid_i[3] = 1'b0;
        #1;
        check("l3_after_pushpop_req", mem_req_o[3], 1'b1);
        tick();
        rd_req_i[3]     = 1'b0;
        mem_gnt_i[3]    = 1'b0;
        mem_rvalid_i[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("l3_drain_rvalid", rd_rvalid_o[3], 1'b1);
            tick();
        end
        mem_rvalid_i[3] = 1'b0;
        #1;
        check("l3_two_left_busy", busy_o, 1'b1);

        // Reset with two tags outstanding on lane 3.
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy",    busy_o,    1'b0);
        check("mid_rst_mem_req", mem_req_o, 4'h0);
        check("mid_rst_rd_gnt",  rd_gnt_o,  4'h0);
        tick();
        rst_ni = 1'b1;
        rd_req_i[3]  = 1'b1;
        rd_addr_i[3] = 32'h0000_0310;
        wr_req_i[3]  = 1'b1;
        wr_addr_i[3] = 32'h0000_0320;
        mem_gnt_i[3] = 1'b1;
        #1;
        check("post_rst_rd_gnt", rd_gnt_o[3],   1'b1);
        check("post_rst_wr_gnt", wr_gnt_o[3],   1'b0);
        check("post_rst_addr",   mem_addr_o[3], 32'h310);
        check("post_rst_busy",   busy_o,        1'b1);
        tick();
        rd_req_i[3] = 1'b0;
        #1;
        check("post_rst_wr_gnt2", wr_gnt_o[3], 1'b1);
        tick();
        wr_req_i[3]     = 1'b0;
        mem_gnt_i[3]    = 1'b0;
        mem_rvalid_i[3] = 1'b1;
        #1;
        check("post_rst_resp_rd", rd_rvalid_o[3], 1'b1);
        tick();
        #1;
        check("post_rst_resp_wr", wr_rvalid_o[3], 1'b1);
        tick();
        mem_rvalid_i[3] = 1'b0;
        #1;
        check("post_rst_idle_busy", busy_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_rw_bank_arbiter.md
MEM_RW_BANK_ARBITER -- requirements
Module: mem_rw_bank_arbiter

Interface
REQ-001 SHALL have parameter NumBanks, default 4: number of banks; one arbiter lane per bank.
REQ-002 SHALL have parameter AddrWidth, default 32: byte-address width.
REQ-003 SHALL have parameter DataWidth, default 32: bank data width, multiple of 8.
REQ-004 SHALL have parameter MaxOutstanding, default 4, minimum 1: per-bank in-flight request limit (tag FIFO depth).
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port busy_o, output, 1: any lane requesting or holding outstanding tags.
REQ-008 SHALL have ports rd_req_i/rd_gnt_o, input/output, [NumBanks]: read-side request/grant.
REQ-009 SHALL have ports rd_addr_i, rd_wdata_i, rd_strb_i, rd_atop_i, rd_we_i, inputs, [NumBanks] of AddrWidth/DataWidth/DataWidth/8/axi_pkg::atop_t/1: read-side payload.
REQ-010 SHALL have ports rd_rvalid_o/rd_rdata_o, outputs, [NumBanks] of 1/DataWidth: read-side response.
REQ-011 SHALL have ports wr_* identical in name suffix, direction and width to REQ-008..010: write-side requester.
REQ-012 SHALL have ports mem_req_o, mem_gnt_i, mem_addr_o, mem_wdata_o, mem_strb_o, mem_atop_o, mem_we_o, mem_rvalid_i, mem_rdata_i, [NumBanks], same widths: single-ported bank side.

Function (per lane b, all lanes independent)
REQ-013 SHALL select side sel (0=rd, 1=wr): only one side requesting -> that side; both -> side given by priority register prio_q.
REQ-014 SHALL hold sel while lock_q set; lock_q sets when mem_req_o[b]=1 and mem_gnt_i[b]=0, clears on handshake.
REQ-015 SHALL drive mem_req_o[b] = selected side req AND NOT fifo_full; payload outputs = selected side payload (zero-latency, combinational).
REQ-016 SHALL assert <sel>_gnt_o[b] = mem_req_o[b] AND mem_gnt_i[b]; the non-selected side's gnt SHALL be 0.
REQ-017 SHALL, on handshake, set prio_q to the non-winning side (round-robin); no handshake -> prio_q unchanged.
REQ-018 SHALL push sel into a MaxOutstanding-deep tag FIFO on every handshake, reads and writes alike.
REQ-019 SHALL pop the tag FIFO on mem_rvalid_i[b] and route mem_rvalid_i/mem_rdata_i combinationally to the head-tag side; other side rvalid=0, rdata='0.
REQ-020 SHALL block new requests when fifo full even if mem_rvalid_i pops in the same cycle (no rvalid->req path).
REQ-021 SHALL accept simultaneous push and pop when not full; count unchanged.
REQ-022 SHALL drop mem_rvalid_i on empty FIFO (no side rvalid) and flag it with a simulation assertion.
REQ-023 SHALL drive busy_o = OR over lanes of (rd_req_i | wr_req_i | fifo non-empty).
REQ-024 SHALL flag via assertion a requester deasserting req or changing payload while req=1 and gnt=0.

Reset
REQ-025 SHALL on rst_ni=0 asynchronously clear prio_q to 0 (rd preferred), lock_q to 0, all tag FIFOs to empty.
REQ-026 SHALL, in reset, yield mem_req_o=0, rd/wr_gnt_o=0, rd/wr_rvalid_o=0, busy_o=0 (inputs idle).
REQ-027 SHALL discard outstanding tags on reset mid-operation; responses arriving after reset are dropped per REQ-022.

Verification
REQ-028 Both sides request lane 0, gnt=1 constant, 4 cycles -> grants rd,wr,rd,wr; tags pushed 0,1,0,1.
REQ-029 Only wr requests lane 2, addr 0x40, we=1, gnt=1 -> mem_addr_o[2]=0x40 same cycle; rvalid 2 cycles later -> wr_rvalid_o[2]=1, rd_rvalid_o[2]=0.
REQ-030 rd selected, mem_gnt_i=0 for 3 cycles, wr asserts in cycle 1 -> sel stays rd until gnt; next grant goes wr.
REQ-031 MaxOutstanding=4, 4 handshakes no rvalid -> mem_req_o=0 with req pending; rvalid+req same cycle -> still 0; next cycle req=1.
REQ-032 Reset asserted with 2 tags outstanding -> outputs 0 immediately, busy_o=0; post-reset rd-only request granted in first cycle.
